cbx_param_ccff: RTL and testbench

CBX_PARAM_CCFF -- requirements
Module: cbx_param_ccff

---
 rtl/cbx_param_pkg.sv | 35 +++
 rtl/cbx_ipin_mux.sv | 42 ++++
 rtl/cbx_param_ccff.sv | 185 ++++++++++++++++++
 tb/tb_cbx_param_ccff.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbx_param_pkg.sv
// -----------------------------------------------------------------------------
// cbx_param_pkg
// Shared definitions for the parameterised connection box (cbx_param_ccff):
//   - sel_width()   : select field width of one ipin mux
//   - total_bits()  : length of the configuration shadow chain
//   - track_index() : channel track feeding a given mux input pair
//   - cfg_state_e   : configuration chain fill state
// -----------------------------------------------------------------------------
package cbx_param_pkg;

    // Fill state of the shadow configuration chain.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } cfg_state_e;

    // Binary select width for a mux with mux_size inputs (mux_size >= 2).
    function automatic int sel_width(input int mux_size);
        return $clog2(mux_size);
    endfunction

    // Number of shadow bits: one select field per driven grid pin.
    function automatic int total_bits(input int num_ipin, input int mux_size);
        return num_ipin * sel_width(mux_size);
    endfunction

    // Track used by mux input pair 'pair' of pin 'pin'. Consecutive pairs are
    // spread across the channel by 'stride' so that pins see different tracks.
    function automatic int track_index(input int pin, input int pair,
                                       input int stride, input int chan_width);
        return (pin + pair * stride) % chan_width;
    endfunction

endpackage

// File: rtl/cbx_ipin_mux.sv
// -----------------------------------------------------------------------------
// cbx_ipin_mux
// One grid input-pin multiplexer of the connection box.
// Ports:
//   i_data  [MUX_SIZE-1:0] : candidate track values
//   i_sel   [SEL_W-1:0]    : binary select from the active configuration
//   i_valid                : active configuration has been committed
//   o_out                  : selected value; 0 when invalid or select out of range
// -----------------------------------------------------------------------------
module cbx_ipin_mux
    import cbx_param_pkg::*;
#(
    parameter int MUX_SIZE = 6,
    parameter int SEL_W    = sel_width(MUX_SIZE)
) (
    input  logic [MUX_SIZE-1:0] i_data,
    input  logic [SEL_W-1:0]    i_sel,
    input  logic                i_valid,
    output logic                o_out
);

    logic w_out;

    // Decoded select: unmatched codes (>= MUX_SIZE) fall through to 0.
    always_comb begin
        w_out = 1'b0;
        if (i_valid) begin
            for (int k = 0; k < MUX_SIZE; k++) begin
                if (i_sel == SEL_W'(k)) begin
                    w_out = i_data[k];
                end else begin
                    w_out = w_out;
                end
            end
        end else begin
            w_out = 1'b0;
        end
    end

    assign o_out = w_out;

endmodule

// File: rtl/cbx_param_ccff.sv
// -----------------------------------------------------------------------------
// cbx_param_ccff
// Connection box with a serial (configuration-chain) programmed shadow register
// and a separately committed active configuration.
//
// Optional feature macro: CBX_CFG_PARITY_EN
//   defined   -> adds input ccff_parity; a commit only happens when the XOR of
//                the shadow chain equals ccff_parity, otherwise cfg_err is set.
//   undefined -> no parity port, no parity check.
//
// Ports:
//   prog_clk                    : configuration clock
//   pReset                      : asynchronous active-low reset
//   ccff_head                   : serial configuration data in
//   ccff_shift_en               : shift one bit into the shadow chain
//   ccff_load                   : commit shadow chain to the active config
//   ccff_parity                 : expected shadow parity (macro only)
//   chanx_left_in/right_in      : channel tracks in
//   chanx_left_out/right_out    : pass-through tracks (crossed over)
//   ipin_out  [NUM_IPIN-1:0]    : grid input pin drives
//   ccff_tail                   : serial configuration data out
//   cfg_full / cfg_valid / cfg_err : chain full, config committed, sticky error
// -----------------------------------------------------------------------------
module cbx_param_ccff
    import cbx_param_pkg::*;
#(
    parameter int CHAN_WIDTH   = 11,
    parameter int NUM_IPIN     = 8,
    parameter int MUX_SIZE     = 6,
    parameter int TRACK_STRIDE = 5
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  ccff_head,
    input  logic                  ccff_shift_en,
    input  logic                  ccff_load,
`ifdef CBX_CFG_PARITY_EN
    input  logic                  ccff_parity,
`endif
    input  logic [CHAN_WIDTH-1:0] chanx_left_in,
    input  logic [CHAN_WIDTH-1:0] chanx_right_in,
    output logic [CHAN_WIDTH-1:0] chanx_left_out,
    output logic [CHAN_WIDTH-1:0] chanx_right_out,
    output logic [NUM_IPIN-1:0]   ipin_out,
    output logic                  ccff_tail,
    output logic                  cfg_full,
    output logic                  cfg_valid,
    output logic                  cfg_err
);

    localparam int SEL_W = sel_width(MUX_SIZE);
    localparam int TOTAL = total_bits(NUM_IPIN, MUX_SIZE);
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LP_TOTAL = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    cfg_state_e        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [TOTAL-1:0]  r_shadow;
    logic [TOTAL-1:0]  r_active;
    logic              r_valid;
    logic              r_err;
    logic              r_full;

    // ------------------------------------------------------------------
    // Next-value helpers
    // ------------------------------------------------------------------
    logic [TOTAL-1:0]  w_head_vec;
    logic [TOTAL-1:0]  w_shadow_next;
    logic [CNT_W-1:0]  w_count_inc;
    logic              w_parity_ok;

`ifdef CBX_CFG_PARITY_EN
    function automatic logic calc_parity(input logic [TOTAL-1:0] bits);
        return ^bits;
    endfunction
`endif

    // Serial-in vector: ccff_head lands in bit 0, older bits move toward the tail.
    always_comb begin
        w_head_vec    = '0;
        w_head_vec[0] = ccff_head;
        w_shadow_next = (r_shadow << 1'b1) | w_head_vec;
    end

    // Bit counter saturates at TOTAL; the chain itself keeps shifting past it.
    always_comb begin
        if (r_count == LP_TOTAL) begin
            w_count_inc = r_count;
        end else begin
            w_count_inc = r_count + LP_ONE;
        end
    end

    // Commit qualification: parity must match when the check is built in.
    always_comb begin
`ifdef CBX_CFG_PARITY_EN
        w_parity_ok = (calc_parity(r_shadow) == ccff_parity);
`else
        w_parity_ok = 1'b1;
`endif
    end

    // Configuration FSM: chain fill tracking, commit and sticky error.
    // A load takes priority over a shift arriving in the same cycle.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_state  <= ST_EMPTY;
            r_count  <= '0;
            r_shadow <= '0;
            r_active <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_full   <= 1'b0;
        end else if (ccff_load) begin
            case (r_state)
                ST_FULL: begin
                    if (w_parity_ok) begin
                        r_active <= r_shadow;
                        r_valid  <= 1'b1;
                    end else begin
                        r_err    <= 1'b1;
                    end
                    // Shadow contents are kept; only the fill count restarts.
                    r_count <= '0;
                    r_state <= ST_EMPTY;
                    r_full  <= 1'b0;
                end
                default: begin
                    r_err <= 1'b1;
                end
            endcase
        end else if (ccff_shift_en) begin
            r_shadow <= w_shadow_next;
            r_count  <= w_count_inc;
            if (w_count_inc == LP_TOTAL) begin
                r_state <= ST_FULL;
                r_full  <= 1'b1;
            end else begin
                r_state <= ST_FILLING;
                r_full  <= 1'b0;
            end
        end else begin
            r_state <= r_state;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign chanx_right_out = chanx_left_in;
    assign chanx_left_out  = chanx_right_in;
    assign ccff_tail       = r_shadow[TOTAL-1];
    assign cfg_full        = r_full;
    assign cfg_valid       = r_valid;
    assign cfg_err         = r_err;

    // ------------------------------------------------------------------
    // Input pin muxes: even inputs from the left side, odd from the right,
    // both sides of a pair reading the same track index.
    // ------------------------------------------------------------------
    logic [NUM_IPIN*MUX_SIZE-1:0] w_mux_in;

    for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_pin
        for (genvar gj = 0; gj < MUX_SIZE / 2; gj++) begin : g_pair
            localparam int TRK = track_index(gi, gj, TRACK_STRIDE, CHAN_WIDTH);
            assign w_mux_in[gi*MUX_SIZE + 2*gj]     = chanx_left_in[TRK];
            assign w_mux_in[gi*MUX_SIZE + 2*gj + 1] = chanx_right_in[TRK];
        end

        cbx_ipin_mux #(
            .MUX_SIZE (MUX_SIZE),
            .SEL_W    (SEL_W)
        ) u_ipin_mux (
            .i_data  (w_mux_in[gi*MUX_SIZE +: MUX_SIZE]),
            .i_sel   (r_active[gi*SEL_W +: SEL_W]),
            .i_valid (r_valid),
            .o_out   (ipin_out[gi])
        );
    end

endmodule

// File: tb/tb_cbx_param_ccff.sv
`timescale 1ns/1ps
module tb_cbx_param_ccff;

    localparam int CW  = 11;
    localparam int NP  = 8;
    localparam int TOT = 24;
    localparam int NV  = 7;

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_load;
`ifdef CBX_CFG_PARITY_EN
    logic          ccff_parity;
`endif
    logic [CW-1:0] chanx_left_in;
    logic [CW-1:0] chanx_right_in;
    logic [CW-1:0] chanx_left_out;
    logic [CW-1:0] chanx_right_out;
    logic [NP-1:0] ipin_out;
    logic          ccff_tail;
    logic          cfg_full;
    logic          cfg_valid;
    logic          cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [TOT-1:0] cfg;
        logic [CW-1:0]  left;
        logic [CW-1:0]  right;
        logic [NP-1:0]  exp_ipin;
        string          name;
    } vec_t;

    typedef struct {
        string         name;
        logic [NP-1:0] exp;
    } sb_t;

    vec_t vecs [NV];
    sb_t  sb_q [$];

    cbx_param_ccff #(
        .CHAN_WIDTH   (11),
        .NUM_IPIN     (8),
        .MUX_SIZE     (6),
        .TRACK_STRIDE (5)
    ) dut (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .ccff_head       (ccff_head),
        .ccff_shift_en   (ccff_shift_en),
        .ccff_load       (ccff_load),
`ifdef CBX_CFG_PARITY_EN
        .ccff_parity     (ccff_parity),
`endif
        .chanx_left_in   (chanx_left_in),
        .chanx_right_in  (chanx_right_in),
        .chanx_left_out  (chanx_left_out),
        .chanx_right_out (chanx_right_out),
        .ipin_out        (ipin_out),
        .ccff_tail       (ccff_tail),
        .cfg_full        (cfg_full),
        .cfg_valid       (cfg_valid),
        .cfg_err         (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        ccff_head     = b;
        ccff_shift_en = 1'b1;
        tick();
        ccff_shift_en = 1'b0;
    endtask

    // MSB first, so cfg[TOT-1] ends up at the tail end of the chain.
    task automatic shift_cfg(input logic [TOT-1:0] cfg);
        for (int k = TOT - 1; k >= 0; k--) begin
            shift_bit(cfg[k]);
        end
`ifdef CBX_CFG_PARITY_EN
        ccff_parity = ^cfg;
`endif
    endtask

    task automatic do_load();
        ccff_load = 1'b1;
        tick();
        ccff_load = 1'b0;
    endtask

    task automatic do_reset();
        pReset = 1'b0;
        #2;
        pReset = 1'b1;
        tick();
    endtask

    task automatic sb_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no entry, expected one");
        end else begin
            e = sb_q.pop_front();
            check(e.name, 32'(ipin_out), 32'(e.exp));
        end
    endtask

    logic hist [30];

    initial begin
        pReset         = 1'b0;
        ccff_head      = 1'b0;
        ccff_shift_en  = 1'b0;
        ccff_load      = 1'b0;
        chanx_left_in  = '0;
        chanx_right_in = '0;
`ifdef CBX_CFG_PARITY_EN
        ccff_parity    = 1'b0;
`endif

        // Expected pin values worked out by hand from the track mapping
        // t = (pin + pair*5) mod 11, even select = left, odd select = right.
        vecs[0] = '{cfg: {8{3'd2}}, left: 11'h020, right: 11'h000, exp_ipin: 8'h01, name: "pin0_sel2_left5"};
        vecs[1] = '{cfg: {8{3'd7}}, left: 11'h7FF, right: 11'h7FF, exp_ipin: 8'h00, name: "all_sel7_zero"};
        vecs[2] = '{cfg: {8{3'd1}}, left: 11'h000, right: 11'h5A5, exp_ipin: 8'hA5, name: "all_sel1_right"};
        vecs[3] = '{cfg: {8{3'd5}}, left: 11'h000, right: 11'h401, exp_ipin: 8'h03, name: "all_sel5_wrap"};
        vecs[4] = '{cfg: {3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0},
                    left: 11'h0FF, right: 11'h000, exp_ipin: 8'hF7, name: "pin3_sel7"};
        vecs[5] = '{cfg: {8{3'd6}}, left: 11'h7FF, right: 11'h7FF, exp_ipin: 8'h00, name: "all_sel6_zero"};
        vecs[6] = '{cfg: {{6{3'd0}}, 3'd3, 3'd4}, left: 11'h400, right: 11'h040, exp_ipin: 8'h03, name: "mixed_sel4_sel3"};

        // Reset state
        repeat (2) tick();
        check("rst_full",  32'(cfg_full),  32'd0);
        check("rst_valid", 32'(cfg_valid), 32'd0);
        check("rst_err",   32'(cfg_err),   32'd0);
        check("rst_tail",  32'(ccff_tail), 32'd0);
        check("rst_ipin",  32'(ipin_out),  32'd0);
        pReset = 1'b1;
        tick();

        // Pass-through tracks mirror in the same cycle
        for (int r = 0; r < 4; r++) begin
            chanx_left_in  = CW'($urandom);
            chanx_right_in = CW'($urandom);
            #1;
            check("pt_right_out", 32'(chanx_right_out), 32'(chanx_left_in));
            check("pt_left_out",  32'(chanx_left_out),  32'(chanx_right_in));
        end

        // Table-driven configurations
        for (int v = 0; v < NV; v++) begin
            shift_cfg(vecs[v].cfg);
            check("full_after_24", 32'(cfg_full), 32'd1);
            check("ipin_stable_while_shifting", 32'(ipin_out),
                  (v == 0) ? 32'd0 : 32'(vecs[v-1].exp_ipin));
            do_load();
            check("full_cleared_on_commit", 32'(cfg_full),  32'd0);
            check("valid_after_commit",     32'(cfg_valid), 32'd1);
            check("no_err_after_commit",    32'(cfg_err),   32'd0);
            chanx_left_in  = vecs[v].left;
            chanx_right_in = vecs[v].right;
            sb_q.push_back('{name: vecs[v].name, exp: vecs[v].exp_ipin});
            #1;
            sb_check();
        end

        // Early load (10 shifts): error, active config untouched
        for (int k = 0; k < 10; k++) begin
            shift_bit(1'b1);
        end
        check("full_at_10", 32'(cfg_full), 32'd0);
        do_load();
        check("early_load_err",   32'(cfg_err),   32'd1);
        check("early_load_valid", 32'(cfg_valid), 32'd1);
        check("early_load_ipin",  32'(ipin_out),  32'(vecs[6].exp_ipin));
        tick();
        check("err_sticky", 32'(cfg_err), 32'd1);

        // 30 shifts: saturation, tail delay, then load+shift together
        do_reset();
        for (int k = 0; k < 6; k++) begin
            hist[k] = 1'($urandom);
        end
        for (int k = 0; k < TOT; k++) begin
            hist[6 + k] = vecs[0].cfg[TOT - 1 - k];
        end
        for (int k = 0; k < 30; k++) begin
            shift_bit(hist[k]);
            check("full_during_30_shifts", 32'(cfg_full), (k + 1 >= TOT) ? 32'd1 : 32'd0);
            if (k + 1 >= TOT) begin
                check("tail_delayed", 32'(ccff_tail), 32'(hist[k - 23]));
            end else if (k + 1 == TOT - 1) begin
                check("tail_before_fill", 32'(ccff_tail), 32'd0);
            end else begin
                ccff_head = ccff_head;
            end
        end
`ifdef CBX_CFG_PARITY_EN
        ccff_parity = ^vecs[0].cfg;
`endif
        chanx_left_in  = vecs[0].left;
        chanx_right_in = vecs[0].right;
        ccff_head      = 1'b1;
        ccff_load      = 1'b1;
        ccff_shift_en  = 1'b1;
        sb_q.push_back('{name: "load_shift_commit", exp: vecs[0].exp_ipin});
        tick();
        ccff_load     = 1'b0;
        ccff_shift_en = 1'b0;
        sb_check();
        check("ls_valid", 32'(cfg_valid), 32'd1);
        check("ls_full",  32'(cfg_full),  32'd0);
        check("ls_tail_unshifted", 32'(ccff_tail), 32'(vecs[0].cfg[TOT-1]));
        for (int k = 0; k < TOT - 1; k++) begin
            shift_bit(1'b0);
        end
        check("ls_shift_dropped_23", 32'(cfg_full), 32'd0);
        shift_bit(1'b0);
        check("ls_shift_dropped_24", 32'(cfg_full), 32'd1);

        // Reset mid-shift
        do_reset();
        shift_cfg(vecs[2].cfg);
        do_load();
        chanx_left_in  = vecs[2].left;
        chanx_right_in = vecs[2].right;
        #1;
        check("pre_rst_ipin", 32'(ipin_out), 32'(vecs[2].exp_ipin));
        do_load();
        check("pre_rst_err", 32'(cfg_err), 32'd1);
        for (int k = 0; k < 12; k++) begin
            shift_bit(1'b1);
        end
        check("pre_rst_full_12", 32'(cfg_full), 32'd0);
        #2;
        pReset = 1'b0;
        #1;
        check("mid_rst_full",  32'(cfg_full),  32'd0);
        check("mid_rst_valid", 32'(cfg_valid), 32'd0);
        check("mid_rst_err",   32'(cfg_err),   32'd0);
        check("mid_rst_tail",  32'(ccff_tail), 32'd0);
        check("mid_rst_ipin",  32'(ipin_out),  32'd0);
        pReset = 1'b1;
        tick();
        check("post_rst_ipin", 32'(ipin_out), 32'd0);

`ifdef CBX_CFG_PARITY_EN
        // Wrong parity: error, no commit, counter cleared
        shift_cfg(vecs[2].cfg);
        ccff_parity = ~(^vecs[2].cfg);
        do_load();
        check("par_err",   32'(cfg_err),   32'd1);
        check("par_valid", 32'(cfg_valid), 32'd0);
        check("par_full",  32'(cfg_full),  32'd0);
        check("par_ipin",  32'(ipin_out),  32'd0);
        shift_cfg(vecs[2].cfg);
        do_load();
        check("par_ok_valid", 32'(cfg_valid), 32'd1);
        check("par_ok_ipin",  32'(ipin_out),  32'(vecs[2].exp_ipin));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
